// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, header field layout, injector state type
// and the header packing helper.
package noc_pkg;

   localparam int DATAW     = 32;
   localparam int NODEW     = 4;
   localparam int SEQW      = 8;
   localparam int PKTLEN    = 4;
   localparam int PKTLEN_P1 = PKTLEN + 1;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   // Header layout inside the DATAW payload bits; bit DATAW is the tail flag
   localparam int DST_LSB = 0;
   localparam int SRC_LSB = NODEW;
   localparam int SEQ_LSB = 2 * NODEW;

   typedef enum logic {
      IDLE = 1'b0,
      BODY = 1'b1
   } ni_state_e;

   function automatic logic [DATAW:0] hdr_pack(
      input logic [NODEW-1:0] dst,
      input logic [NODEW-1:0] src,
      input logic [SEQW-1:0]  seq
   );
      logic [DATAW:0] h;
      h = '0;
      h[DST_LSB +: NODEW] = dst;
      h[SRC_LSB +: NODEW] = src;
      h[SEQ_LSB +: SEQW]  = seq;
      return h;
   endfunction

endpackage

// File: rtl/ni_inject.sv
// Network-interface injector: turns a descriptor plus PKTLEN payload words into
// one header flit and PKTLEN body flits. Define NI_SEQ_EN to stamp a sequence count.
module ni_inject
   import noc_pkg::*;
#(
   parameter logic [NODEW-1:0] SRC_ID = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             desc_valid,
   output logic             desc_ready,
   input  logic [NODEW-1:0] desc_dst,
   input  logic             pay_valid,
   output logic             pay_ready,
   input  logic [DATAW-1:0] pay_data,
   output logic [DATAW:0]   fifo_wdata,
   output logic             fifo_wr_en,
   input  logic             fifo_ordy
);

   localparam int CNTW = (PKTLEN > 1) ? $clog2(PKTLEN) : 1;

   ni_state_e        state_reg;
   logic [CNTW-1:0]  cnt_reg;
   logic [SEQW-1:0]  seq_cur;
   logic             desc_hs;
   logic             pay_hs;
   logic             last_body;

   // fifo_ordy lags our own tail write by a cycle, hence the ~fifo_wr_en term
   assign desc_ready = rst_n & (state_reg == IDLE) & fifo_ordy & ~fifo_wr_en;
   assign pay_ready  = rst_n & (state_reg == BODY);
   assign desc_hs    = desc_valid & desc_ready;
   assign pay_hs     = pay_valid & pay_ready;
   assign last_body  = (cnt_reg == CNTW'(PKTLEN - 1));

`ifdef NI_SEQ_EN
   logic [SEQW-1:0] seq_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seq_reg <= '0;
      end else if (desc_hs) begin
         seq_reg <= seq_reg + SEQW'(1);
      end
   end

   assign seq_cur = seq_reg;
`else
   assign seq_cur = '0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         fifo_wr_en <= DISABLE;
         fifo_wdata <= '0;
      end else begin
         fifo_wr_en <= DISABLE;
         case (state_reg)
            IDLE: begin
               if (desc_hs) begin
                  state_reg  <= BODY;
                  cnt_reg    <= '0;
                  fifo_wr_en <= ENABLE;
                  fifo_wdata <= hdr_pack(desc_dst, SRC_ID, seq_cur);
               end
            end
            BODY: begin
               // Space for the whole packet was reserved at header time
               if (pay_hs) begin
                  fifo_wr_en <= ENABLE;
                  fifo_wdata <= {last_body, pay_data};
                  cnt_reg    <= cnt_reg + CNTW'(1);
                  if (last_body) begin
                     state_reg <= IDLE;
                     cnt_reg   <= '0;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/ni_inject.md
NI_INJECT -- requirements
Module: ni_inject

Interface
REQ-001 SHALL have parameter SRC_ID, default 0, node ID of this injector written into every header flit.
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port desc_valid  input  1  packet descriptor offered.
REQ-005 SHALL have port desc_ready  output  1  descriptor accepted when high with desc_valid.
REQ-006 SHALL have port desc_dst  input  NODEW  destination node ID.
REQ-007 SHALL have port pay_valid  input  1  payload word offered.
REQ-008 SHALL have port pay_ready  output  1  payload word accepted when high with pay_valid.
REQ-009 SHALL have port pay_data  input  DATAW  payload word.
REQ-010 SHALL have port fifo_wdata  output  DATAW+1  flit to downstream input FIFO; bit DATAW = tail flag.
REQ-011 SHALL have port fifo_wr_en  output  1  flit write strobe.
REQ-012 SHALL have port fifo_ordy  input  1  downstream FIFO has room for PKTLEN_P1 flits.

Function
REQ-013 SHALL emit each packet as 1 header flit + PKTLEN body flits, PKTLEN_P1 flits in total.
REQ-014 SHALL implement states IDLE, BODY; reset state IDLE.
REQ-015 SHALL drive desc_ready = (state==IDLE) & fifo_ordy & ~fifo_wr_en; the ~fifo_wr_en term covers the one-cycle lag of fifo_ordy after the tail write.
REQ-016 SHALL, on descriptor handshake, go IDLE->BODY, clear body counter, and assert fifo_wr_en with the header flit on the next cycle (1-cycle registered latency).
REQ-017 SHALL build the header: bit DATAW=0, DST field=desc_dst, SRC field=SRC_ID, SEQ field=current sequence count, remaining bits 0.
REQ-018 SHALL drive pay_ready=1 only in BODY; each payload handshake yields a body flit {tail, pay_data} with fifo_wr_en high on the next cycle.
REQ-019 SHALL set the tail bit only on the PKTLEN-th body flit, then return BODY->IDLE on that handshake.
REQ-020 SHALL deassert fifo_wr_en on every cycle without a handshake in the previous cycle; gaps from pay_valid low are legal within a packet.
REQ-021 SHALL NOT check fifo_ordy during BODY; space for the whole packet was reserved at header time, and this block is the FIFO's only writer.
REQ-022 SHALL increment the 8-bit sequence count by 1 per accepted descriptor, wrapping 255->0.
REQ-023 SHALL ignore desc_valid in BODY and pay_valid in IDLE; neither state ever drops an accepted word.

Reset
REQ-024 SHALL on rst_n low set state=IDLE, body counter=0, sequence count=0, fifo_wr_en=0, fifo_wdata=0, desc_ready=0, pay_ready=0.
REQ-025 SHALL abandon any partial packet on reset mid-packet; the downstream FIFO shares rst_n, so no orphan flits remain.

Configuration
REQ-026 SHALL, with NI_SEQ_EN defined, insert the sequence count into the SEQ field and keep the sequence counter.
REQ-027 SHALL, without NI_SEQ_EN, drive SEQ field to 0 and instantiate no sequence counter; all other behaviour is unchanged.

Structure
REQ-028 SHALL take NODEW, SEQW(=8), header field offsets (DST_LSB, SRC_LSB, SEQ_LSB), and the state enum type from noc_pkg, alongside the existing DATAW, PKTLEN, PKTLEN_P1, ENABLE, DISABLE.
REQ-029 SHALL be a single module with no sub-module; header packing is a function in noc_pkg.

Verification (PKTLEN=4, SRC_ID=3, NI_SEQ_EN defined)
REQ-030 Single packet: desc_dst=5, fifo_ordy=1, payload 0xA..0xD back-to-back -> 5 consecutive writes: header (DST=5, SRC=3, SEQ=0, bit DATAW=0), then A,B,C, then D with bit DATAW=1.
REQ-031 Backpressure: fifo_ordy=0 with desc_valid high for 10 cycles -> desc_ready=0, no writes; ordy rises -> header written 1 cycle after handshake.
REQ-032 Payload gaps: pay_valid toggled 1,0,0,1,1,0,1 -> fifo_wr_en mirrors handshakes delayed 1 cycle, tail only on the 4th word.
REQ-033 Back-to-back packets: second descriptor held valid -> desc_ready low in the tail-write cycle, second header SEQ=1; after 256 packets SEQ wraps to 0.
REQ-034 Reset mid-packet: rst_n low after 2 body flits -> next cycle fifo_wr_en=0, state IDLE, next header SEQ=0.
